// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } FETCH_STATE_T;

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} queue between fetch and decode with synchronous flush.
// Storage is deliberately left unreset; only the pointers and count are cleared.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  fetch_entry_t                  wdata_i,
    output fetch_entry_t                  rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem_q [FIFO_DEPTH];
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + AW'(1);
            if (pop_i)  head_q <= head_q + AW'(1);
            if (push_i && !pop_i)
                count_q <= count_q + CW'(1);
            else if (pop_i && !push_i)
                count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !rst_i)
            mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, RUN/HALTED control and redirect handling in front of the fetch queue.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky misalign_err output for unaligned redirects.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    FETCH_STATE_T   state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic           push, pop;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    fetch_entry_t   head, push_entry;

    // A redirect cancels any handshake in the same cycle, so pop is masked as well as push.
    assign dec_valid  = !fifo_empty;
    assign pop        = dec_valid && dec_ready && !redirect_valid;
    assign push       = (state_q == RUN) && !redirect_valid && (!fifo_full || pop);
    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = {redirect_pc[31:2], 2'b00};
        end else begin
            if (state_q == RUN && halt) state_d = HALTED;
            if (push)                   pc_d    = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign dec_instr = dec_valid ? head.instr : '0;
    assign dec_pc    = dec_valid ? head.pc    : '0;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            misalign_q <= 1'b1;
    end

    assign misalign_err = misalign_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{fifo_count, redirect_pc[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit (FIFO_DEPTH=2, RESET_PC=0).
// Build with FETCH_MISALIGN_CHK_EN defined to also check the sticky misalign flag.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    // Async-read memory model with a recognisable per-word pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = {21'b0, addr[12:2]};
        return 32'h5A00_0000 ^ (idx * 32'h0001_0003);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        halt;
        logic        rdy;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] addr;
        int unsigned cnt;
    } vec_t;

    localparam int unsigned NV = 36;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic h, input logic rdy, input logic v,
                                input logic [31:0] pc, input logic [31:0] addr,
                                input int unsigned cnt);
        vec_t t;
        t.rst = r; t.rv = rv; t.rpc = rpc; t.halt = h; t.rdy = rdy;
        t.valid = v; t.pc = pc; t.addr = addr; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] addr);
        chk({tag, "_valid"}, {31'b0, dec_valid}, {31'b0, v});
        chk({tag, "_pc"},    dec_pc,    v ? pc : 32'h0);
        chk({tag, "_instr"}, dec_instr, v ? mem_word(pc) : 32'h0);
        chk({tag, "_addr"},  imem_addr, addr);
    endtask

    logic mis_exp;

    initial begin
        // Each row: inputs held for one cycle; expected outputs are what is visible
        // during that cycle, i.e. the result of all earlier edges.
        //            rst rv  rpc            hlt rdy  val pc             addr           cnt
        tbl[0]  = mk(0, 0, 32'h0,          0, 1,   0, 32'h0,          32'h0,         0);
        tbl[1]  = mk(0, 0, 32'h0,          0, 1,   1, 32'h0,          32'h4,         1);
        tbl[2]  = mk(0, 0, 32'h0,          0, 1,   1, 32'h4,          32'h8,         1);
        tbl[3]  = mk(0, 0, 32'h0,          0, 1,   1, 32'h8,          32'hC,         1);
        tbl[4]  = mk(1, 0, 32'h0,          0, 0,   1, 32'hC,          32'h10,        1);
        tbl[5]  = mk(0, 0, 32'h0,          0, 0,   0, 32'h0,          32'h0,         0);
        tbl[6]  = mk(0, 0, 32'h0,          0, 0,   1, 32'h0,          32'h4,         1);
        tbl[7]  = mk(0, 0, 32'h0,          0, 0,   1, 32'h0,          32'h8,         2);
        tbl[8]  = mk(0, 0, 32'h0,          0, 0,   1, 32'h0,          32'h8,         2);
        tbl[9]  = mk(0, 0, 32'h0,          0, 0,   1, 32'h0,          32'h8,         2);
        tbl[10] = mk(0, 0, 32'h0,          0, 1,   1, 32'h0,          32'h8,         2);
        tbl[11] = mk(0, 0, 32'h0,          0, 1,   1, 32'h4,          32'hC,         2);
        tbl[12] = mk(0, 0, 32'h0,          0, 1,   1, 32'h8,          32'h10,        2);
        tbl[13] = mk(0, 1, 32'h100,        0, 1,   1, 32'hC,          32'h14,        2);
        tbl[14] = mk(0, 0, 32'h0,          0, 1,   0, 32'h0,          32'h100,       0);
        tbl[15] = mk(0, 0, 32'h0,          0, 1,   1, 32'h100,        32'h104,       1);
        tbl[16] = mk(0, 0, 32'h0,          0, 1,   1, 32'h104,        32'h108,       1);
        tbl[17] = mk(0, 1, 32'h20,         0, 1,   1, 32'h108,        32'h10C,       1);
        tbl[18] = mk(0, 0, 32'h0,          1, 0,   0, 32'h0,          32'h20,        0);
        tbl[19] = mk(0, 0, 32'h0,          1, 0,   1, 32'h20,         32'h24,        1);
        tbl[20] = mk(0, 0, 32'h0,          0, 1,   1, 32'h20,         32'h24,        1);
        tbl[21] = mk(0, 0, 32'h0,          0, 1,   0, 32'h0,          32'h24,        0);
        tbl[22] = mk(0, 0, 32'h0,          0, 1,   0, 32'h0,          32'h24,        0);
        tbl[23] = mk(0, 1, 32'h40,         0, 1,   0, 32'h0,          32'h24,        0);
        tbl[24] = mk(0, 0, 32'h0,          0, 1,   0, 32'h0,          32'h40,        0);
        tbl[25] = mk(0, 0, 32'h0,          0, 1,   1, 32'h40,         32'h44,        1);
        tbl[26] = mk(0, 1, 32'h200,        1, 1,   1, 32'h44,         32'h48,        1);
        tbl[27] = mk(0, 0, 32'h0,          0, 1,   0, 32'h0,          32'h200,       0);
        tbl[28] = mk(0, 0, 32'h0,          0, 1,   1, 32'h200,        32'h204,       1);
        tbl[29] = mk(0, 1, 32'h103,        0, 1,   1, 32'h204,        32'h208,       1);
        tbl[30] = mk(0, 0, 32'h0,          0, 1,   0, 32'h0,          32'h100,       0);
        tbl[31] = mk(0, 0, 32'h0,          0, 1,   1, 32'h100,        32'h104,       1);
        tbl[32] = mk(0, 0, 32'h0,          0, 0,   1, 32'h104,        32'h108,       1);
        tbl[33] = mk(0, 0, 32'h0,          0, 0,   1, 32'h104,        32'h10C,       2);
        tbl[34] = mk(1, 1, 32'h300,        0, 1,   1, 32'h104,        32'h10C,       2);
        tbl[35] = mk(0, 0, 32'h0,          0, 0,   0, 32'h0,          32'h0,         0);

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; dec_ready = 1'b0;
        step();
        step();
        mis_exp = 1'b0;

        for (int i = 0; i < int'(NV); i++) begin
            rst            = tbl[i].rst;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            halt           = tbl[i].halt;
            dec_ready      = tbl[i].rdy;
            check_out($sformatf("row%0d", i), tbl[i].valid, tbl[i].pc, tbl[i].addr);
            chk($sformatf("row%0d_count", i), 32'(dut.u_fifo.count_q), tbl[i].cnt);
`ifdef FETCH_MISALIGN_CHK_EN
            chk($sformatf("row%0d_misalign", i), {31'b0, misalign_err}, {31'b0, mis_exp});
`endif
            step();
            if (tbl[i].rst)
                mis_exp = 1'b0;
            else if (tbl[i].rv && tbl[i].rpc[1:0] != 2'b00)
                mis_exp = 1'b1;
        end

        // PC wrap from the top of the address space back to zero.
        rst = 1'b0; halt = 1'b0; dec_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0; redirect_pc = '0;
        check_out("wrap0", 1'b0, 32'h0,         32'hFFFF_FFF8);
        step();
        check_out("wrap1", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        step();
        check_out("wrap2", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000);
        step();
        check_out("wrap3", 1'b1, 32'h0000_0000, 32'h0000_0004);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("wrap_misalign", {31'b0, misalign_err}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
